// File: rtl/sinegen_pkg.sv
// Shared types and default widths for the two-channel sine ROM sequencer.
package sinegen_pkg;

    localparam int ADDRESS_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ACC_WIDTH_DEF     = 16;

    typedef enum logic [1:0] {IDLE, SLOT0, SLOT1} sg_state_t;

    // Which channel a ROM read in flight belongs to.
    typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} sg_chan_t;

endpackage

// File: rtl/phase_acc.sv
// Free-running modulo-2^ACC_WIDTH phase accumulator, advanced by one increment per step strobe.
module phase_acc
    import sinegen_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic [ACC_WIDTH-1:0] incr,
    output logic [ACC_WIDTH-1:0] acc
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc + incr;
        end
    end

endmodule

// File: rtl/sinegen_ctrl.sv
// Two-channel sine sequencer: alternates ROM reads between channel 0 and 1 and
// captures the registered ROM output into per-channel sample registers.
module sinegen_ctrl
    import sinegen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ACC_WIDTH-1:0]     cfg_incr0,
    input  logic [ACC_WIDTH-1:0]     cfg_incr1,
    input  logic [ADDRESS_WIDTH-1:0] cfg_offset1,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic [DATA_WIDTH-1:0]    dout0,
    output logic [DATA_WIDTH-1:0]    dout1,
    output logic                     valid0,
    output logic                     valid1
);

    sg_state_t                state, state_nxt;
    logic [ACC_WIDTH-1:0]     incr0, incr1;
    logic [ACC_WIDTH-1:0]     acc0, acc1;
    logic [ADDRESS_WIDTH-1:0] offset1;
    logic [ADDRESS_WIDTH-1:0] addr0, addr1;
    logic                     cfg_load;
    logic                     pend_vld;
    sg_chan_t                 pend_ch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = SLOT0;
            SLOT0:   state_nxt = SLOT1;
            SLOT1:   state_nxt = en ? SLOT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration is refused only in SLOT0 so a pair never sees half-updated increments.
    assign cfg_ready = (state != SLOT0);
    assign cfg_load  = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            incr0   <= '0;
            incr1   <= '0;
            offset1 <= '0;
        end else if (cfg_load) begin
            incr0   <= cfg_incr0;
            incr1   <= cfg_incr1;
            offset1 <= cfg_offset1;
        end
    end

    phase_acc #(.ACC_WIDTH(ACC_WIDTH)) u_acc0 (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (state == SLOT0),
        .incr  (incr0),
        .acc   (acc0)
    );

    phase_acc #(.ACC_WIDTH(ACC_WIDTH)) u_acc1 (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (state == SLOT1),
        .incr  (incr1),
        .acc   (acc1)
    );

    assign addr0 = acc0[ACC_WIDTH-1 -: ADDRESS_WIDTH];
    assign addr1 = acc1[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset1;

    always_comb begin
        rom_addr = '0;
        case (state)
            SLOT0:   rom_addr = addr0;
            SLOT1:   rom_addr = addr1;
            default: rom_addr = '0;
        endcase
    end

    // The tag follows the read through the ROM's one-cycle latency; reset drops it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_ch  <= CH0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            dout0    <= '0;
            dout1    <= '0;
        end else begin
            pend_vld <= (state != IDLE);
            pend_ch  <= (state == SLOT1) ? CH1 : CH0;
            valid0   <= pend_vld && (pend_ch == CH0);
            valid1   <= pend_vld && (pend_ch == CH1);
            if (pend_vld && (pend_ch == CH0)) dout0 <= rom_data;
            if (pend_vld && (pend_ch == CH1)) dout1 <= rom_data;
        end
    end

endmodule

// File: tb/tb_sinegen_ctrl.sv
// Self-checking bench for sinegen_ctrl: directed vector table, hand sequences and a
// randomized run against a slot-level reference model with a behavioural ROM.
module tb_sinegen_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int ACW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [ACW-1:0] cfg_incr0;
    logic [ACW-1:0] cfg_incr1;
    logic [AW-1:0]  cfg_offset1;
    logic [AW-1:0]  rom_addr;
    logic [DW-1:0]  rom_data = '0;
    logic [DW-1:0]  dout0, dout1;
    logic           valid0, valid1;

    int n_tests = 0;
    int n_fail  = 0;

    sinegen_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_incr0   (cfg_incr0),
        .cfg_incr1   (cfg_incr1),
        .cfg_offset1 (cfg_offset1),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .dout0       (dout0),
        .dout1       (dout1),
        .valid0      (valid0),
        .valid1      (valid1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return DW'(int'(a) * 37 + 11);
    endfunction

    // Registered-output ROM: data for the address presented in cycle t appears in t+1.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en_v);
        rst_n       = 1'b0;
        en          = en_v;
        cfg_valid   = 1'b0;
        cfg_incr0   = '0;
        cfg_incr1   = '0;
        cfg_offset1 = '0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            check("rst_addr",  rom_addr,  0);
            check("rst_ready", cfg_ready, 1);
            check("rst_v0",    valid0,    0);
            check("rst_v1",    valid1,    0);
            check("rst_d0",    dout0,     0);
            check("rst_d1",    dout1,     0);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Offer a configuration for one cycle; caller guarantees IDLE or SLOT1.
    task automatic load_cfg(input logic [ACW-1:0] i0, input logic [ACW-1:0] i1, input logic [AW-1:0] o1);
        cfg_valid   = 1'b1;
        cfg_incr0   = i0;
        cfg_incr1   = i1;
        cfg_offset1 = o1;
        next_cycle();
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic          ready;
        logic          v0;
        logic          v1;
        logic [AW-1:0] d0_idx;
        logic [AW-1:0] d1_idx;
    } vec_t;

    vec_t vecs[12];

    // Reference model state (slot: 0 none, 1 channel-0 read, 2 channel-1 read).
    int unsigned m_acc0, m_acc1, m_i0, m_i1, m_off;
    int          m_slot;
    int          h1_ch, h2_ch;
    int unsigned h1_addr, h2_addr;
    logic [DW-1:0] m_d0, m_d1;

    task automatic model_reset();
        m_acc0 = 0; m_acc1 = 0; m_i0 = 0; m_i1 = 0; m_off = 0;
        m_slot = 0;
        h1_ch = -1; h2_ch = -1; h1_addr = 0; h2_addr = 0;
        m_d0 = '0; m_d1 = '0;
    endtask

    initial begin
        logic [AW-1:0] a0;
        logic [AW-1:0] a1_exp;
        int unsigned   e_addr;

        vecs[0]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[2]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[3]  = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
        vecs[4]  = '{1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0};
        vecs[5]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
        vecs[6]  = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b1, 8'd0, 8'd1};
        vecs[7]  = '{1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0};
        vecs[8]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 8'd0, 8'd2};
        vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0};
        vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd3};
        vecs[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};

        // Reset with en held high, then first SLOT0 and first channel-0 sample.
        do_reset(1'b1);
        @(negedge clk); check("post_rst_idle_ready", cfg_ready, 1);
        next_cycle();
        @(negedge clk); check("first_slot0_ready", cfg_ready, 0);
        next_cycle();
        @(negedge clk); check("first_slot1_ready", cfg_ready, 1);
        next_cycle();
        @(negedge clk);
        check("first_v0", valid0, 1);
        check("first_d0", dout0, 32'(rom_fn(8'd0)));

        // Step sequence and stop, table-driven.
        do_reset(1'b0);
        load_cfg(16'h0100, 16'h0100, 8'd0);
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en;
            @(negedge clk);
            check($sformatf("vec%0d_addr", i),  rom_addr,  32'(vecs[i].addr));
            check($sformatf("vec%0d_ready", i), cfg_ready, 32'(vecs[i].ready));
            check($sformatf("vec%0d_v0", i),    valid0,    32'(vecs[i].v0));
            check($sformatf("vec%0d_v1", i),    valid1,    32'(vecs[i].v1));
            if (vecs[i].v0) check($sformatf("vec%0d_d0", i), dout0, 32'(rom_fn(vecs[i].d0_idx)));
            if (vecs[i].v1) check($sformatf("vec%0d_d1", i), dout1, 32'(rom_fn(vecs[i].d1_idx)));
            next_cycle();
        end

        // Quarter-phase offset across the address wrap.
        do_reset(1'b0);
        load_cfg(16'h0100, 16'h0100, 8'd64);
        en = 1'b1;
        next_cycle();
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            check("q_addr0", rom_addr, 32'(k % 256));
            a0 = rom_addr;
            a1_exp = a0 + 8'd64;
            next_cycle();
            @(negedge clk);
            check("q_addr1", rom_addr, 32'(a1_exp));
            if (k == 200) check("q_wrap_200_to_8", rom_addr, 8);
            next_cycle();
        end
        en = 1'b0;

        // Accumulator wrap 0xFF00 -> 0x0000.
        do_reset(1'b0);
        load_cfg(16'hFF00, 16'h0100, 8'd0);
        en = 1'b1;
        next_cycle();
        @(negedge clk); check("wrap_a0", rom_addr, 0);
        next_cycle();
        cfg_valid = 1'b1; cfg_incr0 = 16'h0100; cfg_incr1 = 16'h0100; cfg_offset1 = 8'd0;
        @(negedge clk); check("wrap_slot1_ready", cfg_ready, 1);
        next_cycle();
        cfg_valid = 1'b0;
        @(negedge clk); check("wrap_a1", rom_addr, 255);
        next_cycle(); next_cycle();
        @(negedge clk); check("wrap_a2", rom_addr, 0);
        next_cycle(); next_cycle();
        @(negedge clk); check("wrap_a3", rom_addr, 1);
        en = 1'b0;

        // Configuration offered in SLOT0 stalls until SLOT1; that SLOT1 step uses old incr1.
        do_reset(1'b0);
        load_cfg(16'h0100, 16'h0100, 8'd0);
        en = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        cfg_valid = 1'b1; cfg_incr0 = 16'h0100; cfg_incr1 = 16'h0400; cfg_offset1 = 8'd0;
        @(negedge clk); check("stall_slot0_ready", cfg_ready, 0);
        next_cycle();
        @(negedge clk);
        check("stall_slot1_ready", cfg_ready, 1);
        check("stall_slot1_addr", rom_addr, 1);
        next_cycle();
        cfg_valid = 1'b0;
        @(negedge clk); check("stall_next_a0", rom_addr, 2);
        next_cycle();
        @(negedge clk); check("stall_old_incr1", rom_addr, 2);
        next_cycle(); next_cycle();
        @(negedge clk); check("stall_new_incr1", rom_addr, 6);
        next_cycle();

        // Mid-run reset in SLOT0 discards the in-flight capture.
        @(negedge clk); check("mid_slot0_ready", cfg_ready, 0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_v0",    valid0,    0);
            check("mid_rst_v1",    valid1,    0);
            check("mid_rst_d0",    dout0,     0);
            check("mid_rst_d1",    dout1,     0);
            check("mid_rst_addr",  rom_addr,  0);
            check("mid_rst_ready", cfg_ready, 1);
            next_cycle();
        end

        // Randomized run against the reference model.
        do_reset(1'b0);
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            en          = (($urandom % 10) < 7);
            cfg_valid   = (($urandom % 5) == 0);
            cfg_incr0   = (($urandom % 8) == 0) ? 16'h0000 : ACW'($urandom);
            cfg_incr1   = ACW'($urandom);
            cfg_offset1 = AW'($urandom);
            @(negedge clk);
            case (m_slot)
                1:       e_addr = (m_acc0 >> (ACW - AW)) % 256;
                2:       e_addr = ((m_acc1 >> (ACW - AW)) + m_off) % 256;
                default: e_addr = 0;
            endcase
            if (h2_ch == 0) m_d0 = rom_fn(AW'(h2_addr));
            if (h2_ch == 1) m_d1 = rom_fn(AW'(h2_addr));
            check("rnd_addr",  rom_addr,  e_addr);
            check("rnd_ready", cfg_ready, 32'(m_slot != 1));
            check("rnd_v0",    valid0,    32'(h2_ch == 0));
            check("rnd_v1",    valid1,    32'(h2_ch == 1));
            check("rnd_d0",    dout0,     32'(m_d0));
            check("rnd_d1",    dout1,     32'(m_d1));
            h2_ch   = h1_ch;
            h2_addr = h1_addr;
            h1_ch   = (m_slot == 0) ? -1 : m_slot - 1;
            h1_addr = e_addr;
            if (m_slot == 1) m_acc0 = (m_acc0 + m_i0) % 65536;
            if (m_slot == 2) m_acc1 = (m_acc1 + m_i1) % 65536;
            if (cfg_valid && m_slot != 1) begin
                m_i0  = cfg_incr0;
                m_i1  = cfg_incr1;
                m_off = cfg_offset1;
            end
            m_slot = (m_slot == 1) ? 2 : (en ? 1 : 0);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
